// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared switch-input constants and debouncer state type
package io_pkg;

    localparam int SW_WIDTH              = 12;
    localparam int BOARD_DEBOUNCE_CYCLES = 1_000_000;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch line: synchroniser chain plus debounce FSM
module debounce_bit
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic accept_o,
    output logic idle_o
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit                IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   s;
    logic                   differ;

    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = (s != stable_q);

    // Accept on the edge where the differing level has been seen DEBOUNCE_CYCLES times.
    always_comb begin
        accept_o = 1'b0;
        if (differ) begin
            if (state_q == IDLE) accept_o = IMMEDIATE;
            else                 accept_o = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (differ) begin
                        if (IMMEDIATE) begin
                            stable_q <= s;
                        end else begin
                            state_q <= COUNT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (!differ) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q <= s;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign stable_o = stable_q;
    assign idle_o   = (state_q == IDLE);

endmodule

// File: rtl/sw_input_debounce.sv
// rtl/sw_input_debounce.sv - synchronised, per-bit debounced slide-switch bank
module sw_input_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] data_stable,
    output logic             change_pulse,
    output logic             settled
);

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] idle;
    logic             change_pulse_q;
    logic             change_pulse_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (sw_raw[i]),
            .stable_o (data_stable[i]),
            .accept_o (accept[i]),
            .idle_o   (idle[i])
        );
    end

    // Same edge that loads data_stable raises the pulse, so both appear together.
    assign change_pulse_d = |accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) change_pulse_q <= 1'b0;
        else        change_pulse_q <= change_pulse_d;
    end

    assign change_pulse = change_pulse_q;
    assign settled      = &idle;

endmodule

// File: tb/tb_sw_input_debounce.sv
// tb/tb_sw_input_debounce.sv - directed self-checking bench for sw_input_debounce
module tb_sw_input_debounce;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sw_raw;
    logic [11:0] data_stable;
    logic        change_pulse;
    logic        settled;

    int checks   = 0;
    int failures = 0;

    sw_input_debounce #(
        .WIDTH           (12),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_raw       (sw_raw),
        .data_stable  (data_stable),
        .change_pulse (change_pulse),
        .settled      (settled)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [11:0] d, input logic p, input logic s);
        check({tag, "_data"}, data_stable, d);
        check({tag, "_pulse"}, {11'd0, change_pulse}, {11'd0, p});
        check({tag, "_settled"}, {11'd0, settled}, {11'd0, s});
    endtask

    logic [5:0] bounce;

    initial begin
        // 1: switches on through reset
        rst_n  = 1'b0;
        sw_raw = 12'hFFF;
        tick(3);
        check_state("rst_hold", 12'h000, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick(2);
        check_state("rst_e2", 12'h000, 1'b0, 1'b1);
        tick(1);
        check_state("rst_e3", 12'h000, 1'b0, 1'b0);
        tick(2);
        check_state("rst_e5", 12'h000, 1'b0, 1'b0);
        tick(1);
        check_state("rst_e6", 12'hFFF, 1'b1, 1'b1);
        tick(1);
        check_state("rst_e7", 12'hFFF, 1'b0, 1'b1);

        // 2: return to zero, then 0A5
        sw_raw = 12'h000;
        tick(10);
        check_state("zero", 12'h000, 1'b0, 1'b1);
        sw_raw = 12'h0A5;
        tick(2);
        check_state("a5_e2", 12'h000, 1'b0, 1'b1);
        tick(1);
        check_state("a5_e3", 12'h000, 1'b0, 1'b0);
        tick(2);
        check_state("a5_e5", 12'h000, 1'b0, 1'b0);
        tick(1);
        check_state("a5_e6", 12'h0A5, 1'b1, 1'b1);
        tick(1);
        check_state("a5_e7", 12'h0A5, 1'b0, 1'b1);
        sw_raw = 12'h000;
        tick(10);
        check_state("a5_clr", 12'h000, 1'b0, 1'b1);

        // 3: three-cycle glitch on bit 0 is rejected
        sw_raw = 12'h001;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 3) sw_raw = 12'h000;
            check("glitch_data", data_stable, 12'h000);
            check("glitch_pulse", {11'd0, change_pulse}, 12'h000);
        end
        check("glitch_settled", {11'd0, settled}, 12'h001);

        // 4: bounce on bit 3, last low sample at edge 2 -> accept at edge 8
        bounce = 6'b111101;
        for (int k = 0; k < 6; k++) begin
            sw_raw = {8'd0, bounce[k], 3'd0};
            tick(1);
            check("bounce_data", data_stable, 12'h000);
        end
        tick(1);
        check_state("bounce_e7", 12'h000, 1'b0, 1'b0);
        tick(1);
        check_state("bounce_e8", 12'h008, 1'b1, 1'b1);
        sw_raw = 12'h000;
        tick(10);
        check_state("bounce_clr", 12'h000, 1'b0, 1'b1);

        // 5: staggered bits produce separate pulses
        sw_raw = 12'h002;
        tick(2);
        sw_raw = 12'h082;
        tick(3);
        check_state("stag_e5", 12'h000, 1'b0, 1'b0);
        tick(1);
        check_state("stag_e6", 12'h002, 1'b1, 1'b0);
        tick(1);
        check_state("stag_e7", 12'h002, 1'b0, 1'b0);
        tick(1);
        check_state("stag_e8", 12'h082, 1'b1, 1'b1);
        tick(1);
        check_state("stag_e9", 12'h082, 1'b0, 1'b1);
        sw_raw = 12'h000;
        tick(10);
        check_state("stag_clr", 12'h000, 1'b0, 1'b1);

        // 6: reset mid-count discards progress
        sw_raw = 12'h004;
        tick(3);
        check_state("mid_e3", 12'h000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_state("mid_rst", 12'h000, 1'b0, 1'b1);
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check("mid_wait_data", data_stable, 12'h000);
            check("mid_wait_pulse", {11'd0, change_pulse}, 12'h000);
        end
        tick(1);
        check_state("mid_e6", 12'h004, 1'b1, 1'b1);
        tick(1);
        check_state("mid_e7", 12'h004, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
